// File: rtl/ldca_arb_pkg.sv
// Shared types and helpers for the ldca shared-adder arbiter.
package ldca_arb_pkg;

  localparam int RSP_FIFO_DEPTH   = 2;
  localparam int DEF_ADDER_LENGTH = 32;
  localparam int DEF_ID_W         = 2;

  // Id width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_ADDER_LENGTH:0] sum;
    logic [DEF_ID_W-1:0]       id;
  } ldca_rsp_t;

endpackage

// File: rtl/ldca_adder.sv
// Low-precision adder: approximated low part, exact upper part seeded by a[IMPRECISE_PART-1].
module ldca_adder #(
  parameter int ADDER_LENGTH       = 32,
  parameter int IMPRECISE_PART     = 16,
  parameter int IMPRECISE_SUB_PART = 8
) (
  input  logic [ADDER_LENGTH-1:0] a,
  input  logic [ADDER_LENGTH-1:0] b,
  output logic [ADDER_LENGTH:0]   sum
);

  localparam int HI_W = ADDER_LENGTH - IMPRECISE_PART;

  logic [HI_W:0] hi;
  logic          unused_low;

  assign hi = {1'b0, a[ADDER_LENGTH-1:IMPRECISE_PART]}
            + {1'b0, b[ADDER_LENGTH-1:IMPRECISE_PART]}
            + (HI_W+1)'(a[IMPRECISE_PART-1]);

  assign sum = {hi, b[IMPRECISE_PART-1:IMPRECISE_SUB_PART], {IMPRECISE_SUB_PART{1'b1}}};

  assign unused_low = ^{a[IMPRECISE_PART-2:0], b[IMPRECISE_SUB_PART-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import ldca_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = grant_vld;
  end

endmodule

// File: rtl/ldca_shared_adder_arb.sv
// One ldca_adder shared by NUM_REQ requesters via round-robin, results queued in a 2-entry FIFO.
// Define LDCA_ARB_PERF_EN to add the saturating stall_cnt port.
module ldca_shared_adder_arb
  import ldca_arb_pkg::*;
#(
  parameter  int NUM_REQ            = 4,
  parameter  int ADDER_LENGTH       = 32,
  parameter  int IMPRECISE_PART     = 16,
  parameter  int IMPRECISE_SUB_PART = 8,
  localparam int ID_W               = clog2_min1(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ADDER_LENGTH:0]           rsp_sum,
`ifdef LDCA_ARB_PERF_EN
  output logic [15:0]                     stall_cnt,
`endif
  output logic [ID_W-1:0]                 rsp_id
);

  typedef struct packed {
    logic [ADDER_LENGTH:0] sum;
    logic [ID_W-1:0]       id;
  } rsp_t;

  rsp_t                    mem [RSP_FIFO_DEPTH];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;
  logic [ID_W-1:0]         rr_ptr, g_idx;
  logic [NUM_REQ-1:0]      g_onehot;
  logic                    g_vld;
  logic                    pop, push, can_accept;
  logic [ADDER_LENGTH-1:0] mux_a, mux_b;
  logic [ADDER_LENGTH:0]   add_sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (g_onehot),
    .grant_idx (g_idx),
    .grant_vld (g_vld)
  );

  assign mux_a = req_a[int'(g_idx)*ADDER_LENGTH +: ADDER_LENGTH];
  assign mux_b = req_b[int'(g_idx)*ADDER_LENGTH +: ADDER_LENGTH];

  ldca_adder #(
    .ADDER_LENGTH       (ADDER_LENGTH),
    .IMPRECISE_PART     (IMPRECISE_PART),
    .IMPRECISE_SUB_PART (IMPRECISE_SUB_PART)
  ) u_adder (
    .a   (mux_a),
    .b   (mux_b),
    .sum (add_sum)
  );

  // A pop in the same cycle frees the slot the push lands in.
  assign rsp_valid  = (count != 2'd0);
  assign pop        = rsp_valid && rsp_ready;
  assign can_accept = (count < 2'(RSP_FIFO_DEPTH)) || pop;
  assign req_ready  = can_accept ? g_onehot : '0;
  assign push       = g_vld && can_accept;

  assign rsp_sum = mem[rd_ptr].sum;
  assign rsp_id  = mem[rd_ptr].id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rr_ptr <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{sum: add_sum, id: g_idx};
        wr_ptr      <= ~wr_ptr;
        rr_ptr      <= (int'(g_idx) == NUM_REQ-1) ? '0 : g_idx + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef LDCA_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          stall_cnt <= 16'd0;
    else if (|req_valid && !can_accept && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ldca_shared_adder_arb.sv
// Self-checking bench for ldca_shared_adder_arb: vector table, scoreboard, and corner sequences.
module tb_ldca_shared_adder_arb;

  localparam int N = 4;
  localparam int L = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*L-1:0]   req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [L:0]       rsp_sum;
  logic [1:0]       rsp_id;
`ifdef LDCA_ARB_PERF_EN
  logic [15:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  ldca_shared_adder_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
`ifdef LDCA_ARB_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .rsp_id    (rsp_id)
  );

  typedef struct {
    logic [L:0] sum;
    logic [1:0] id;
  } exp_t;

  typedef struct {
    logic [1:0]   id;
    logic [L-1:0] a;
    logic [L-1:0] b;
    logic [L:0]   sum;
  } vec_t;

  exp_t         sb[$];
  exp_t         e;
  vec_t         tab[6];
  int           tests = 0;
  int           fails = 0;
  int           m_ptr, m_cnt, m_stall, acc_seen, cg, start;
  bit           chk_en, cpop, ccan;
  logic [N-1:0] cexp;

  function automatic logic [L:0] model(input logic [L-1:0] a, input logic [L-1:0] b);
    logic [L:0] s;
    s[7:0]  = 8'hFF;
    s[15:8] = b[15:8];
    s[L:16] = {1'b0, a[L-1:16]} + {1'b0, b[L-1:16]} + 17'(a[15]);
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr   = 0;
    m_cnt   = 0;
    m_stall = 0;
  endtask

  // Reference arbiter/FIFO model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cg = -1;
      for (int k = 0; k < N; k++)
        if (cg < 0 && req_valid[(m_ptr + k) % N]) cg = (m_ptr + k) % N;
      cpop = (m_cnt > 0) && rsp_ready;
      ccan = (m_cnt < 2) || cpop;
      cexp = '0;
      if (cg >= 0 && ccan) cexp[cg] = 1'b1;
      check("req_ready", req_ready, cexp);
      check("rsp_valid", rsp_valid, m_cnt > 0);
      if (m_cnt > 0) begin
        check("rsp_sum", rsp_sum, sb[0].sum);
        check("rsp_id", rsp_id, sb[0].id);
      end
`ifdef LDCA_ARB_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      if (|req_valid && !ccan && m_stall < 65535) m_stall++;
`endif
      if (req_ready != '0) acc_seen++;
      if (cpop) begin
        void'(sb.pop_front());
        m_cnt--;
      end
      if (cg >= 0 && ccan) begin
        e.sum = model(req_a[cg*L +: L], req_b[cg*L +: L]);
        e.id  = 2'(cg);
        sb.push_back(e);
        m_cnt++;
        m_ptr = (cg + 1) % N;
      end
    end
  end

  initial begin
    tab[0] = '{2'd0, 32'h0001_0000, 32'h0002_0000, 33'h0_0003_00FF};
    tab[1] = '{2'd1, 32'hFFFF_8000, 32'h0000_0000, 33'h1_0000_00FF};
    tab[2] = '{2'd2, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_00FF};
    tab[3] = '{2'd3, 32'h0000_7FFF, 32'h0000_1234, 33'h0_0000_12FF};
    tab[4] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF};
    tab[5] = '{2'd2, 32'h1234_0000, 32'h1111_AB00, 33'h0_2345_ABFF};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    chk_en    = 1'b0;
    acc_seen  = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single-request vectors: one-cycle latency and adder arithmetic.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_a[int'(tab[i].id)*L +: L] = tab[i].a;
      req_b[int'(tab[i].id)*L +: L] = tab[i].b;
      req_valid = '0;
      req_valid[tab[i].id] = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      check("tab_valid", rsp_valid, 1);
      check("tab_sum", rsp_sum, tab[i].sum);
      check("tab_id", rsp_id, tab[i].id);
    end

    // All requesters continuously valid: round-robin, one accept per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_a[i*L +: L] = $urandom();
      req_b[i*L +: L] = $urandom();
    end
    start     = m_ptr;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("rr_order", rsp_id, 64'((start + k) % N));
    end

    // Drain, then block the output: exactly two accepts fill the FIFO.
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check("drained", rsp_valid, 0);
    acc_seen  = 0;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (6) @(posedge clk);
    #1;
    check("full_accepts", acc_seen, 2);
    check("full_ready", req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_and_accept", |req_ready, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("refull_ready", req_ready, 0);
    check("refull_valid", rsp_valid, 1);

    // Asynchronous reset with a full FIFO.
    @(posedge clk); #3;
    chk_en    = 1'b0;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("async_rsp_valid", rsp_valid, 0);
    check("async_rsp_sum", rsp_sum, 0);
    check("async_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    check("post_rst_valid", rsp_valid, 0);
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    repeat (5) @(posedge clk);
    #1;
    req_valid = '0;

`ifdef LDCA_ARB_PERF_EN
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk_en    = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    repeat (7) @(posedge clk);
    #1;
    check("stall_5", stall_cnt, 5);
    repeat (70000) @(posedge clk);
    #1;
    check("stall_sat", stall_cnt, 16'hFFFF);
    req_valid = '0;
`endif

    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("final_empty", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
